// File: rtl/pal_test_timing_gen.sv
// PAL-style test-pattern timing generator: line/frame counters, separate and composite
// syncs, and four selectable colour patterns, all registered with a one-clock latency.
module pal_test_timing_gen #(
    parameter int unsigned HTOTAL       = 448,
    parameter int unsigned VTOTAL       = 312,
    parameter int unsigned HACTIVE      = 256,
    parameter int unsigned VACTIVE      = 192,
    parameter int unsigned HBLANK_START = 320,
    parameter int unsigned HBLANK_END   = 416,
    parameter int unsigned HSYNC_START  = 344,
    parameter int unsigned HSYNC_END    = 376,
    parameter int unsigned VSYNC_START  = 248,
    parameter int unsigned VSYNC_END    = 252
) (
    input  logic       clkvideo,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic [2:0] border,
    output logic [2:0] ro,
    output logic [2:0] go,
    output logic [2:0] bo,
    output logic       hsync_ext_n,
    output logic       vsync_ext_n,
    output logic       csync_ext_n,
    output logic       frame_tick,
    output logic [4:0] frame_cnt
);

    localparam logic [8:0] H_LAST = 9'(HTOTAL - 1);
    localparam logic [8:0] V_LAST = 9'(VTOTAL - 1);
    localparam logic [8:0] H_ACT  = 9'(HACTIVE);
    localparam logic [8:0] V_ACT  = 9'(VACTIVE);
    localparam logic [8:0] HB_S   = 9'(HBLANK_START);
    localparam logic [8:0] HB_E   = 9'(HBLANK_END);
    localparam logic [8:0] HS_S   = 9'(HSYNC_START);
    localparam logic [8:0] HS_E   = 9'(HSYNC_END);
    localparam logic [8:0] VS_S   = 9'(VSYNC_START);
    localparam logic [8:0] VS_E   = 9'(VSYNC_END);

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_GREY  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_ANIM  = 2'd3
    } pattern_e;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
    } rgb_t;

    logic [8:0] hcnt_q, hcnt_d;
    logic [8:0] vcnt_q, vcnt_d;
    pattern_e   mode_q, mode_d;
    logic [4:0] frm_q, frm_d;          // frame number tracked alongside the counters
    logic       wrap_q, wrap_d;        // counters wrapped to 0,0 on the previous edge
    rgb_t       colour_q, colour_d;
    logic       hsync_n_q, hsync_n_d;
    logic       vsync_n_q, vsync_n_d;
    logic       csync_n_q, csync_n_d;
    logic       frame_tick_q, frame_tick_d;
    logic [4:0] frame_cnt_q, frame_cnt_d;

    logic       h_last, frame_wrap, hs_act, vs_act, blank, active;
    logic [2:0] bar_k;
    rgb_t       pat;

    function automatic rgb_t bar_colour(input logic [2:0] k);
        bar_colour.r = {3{k[1]}};
        bar_colour.g = {3{k[2]}};
        bar_colour.b = {3{k[0]}};
    endfunction

    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        h_last     = (hcnt_q == H_LAST);
        frame_wrap = h_last && (vcnt_q == V_LAST);

        hcnt_d = h_last ? 9'd0 : hcnt_q + 9'd1;
        vcnt_d = vcnt_q;
        if (h_last) begin
            vcnt_d = (vcnt_q == V_LAST) ? 9'd0 : vcnt_q + 9'd1;
        end

        // Pattern and frame number change only at the frame boundary.
        mode_d = frame_wrap ? pattern_e'(mode) : mode_q;
        frm_d  = frame_wrap ? frm_q + 5'd1 : frm_q;
        wrap_d = frame_wrap;

        hs_act = (hcnt_q >= HS_S) && (hcnt_q < HS_E);
        vs_act = (vcnt_q >= VS_S) && (vcnt_q < VS_E);
        blank  = ((hcnt_q >= HB_S) && (hcnt_q < HB_E)) || vs_act;
        active = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);

        bar_k = hcnt_q[7:5] + frm_q[4:2];
        pat   = '0;
        unique case (mode_q)
            PAT_BARS:  pat = bar_colour(hcnt_q[7:5]);
            PAT_GREY:  pat = '{r: hcnt_q[7:5], g: hcnt_q[7:5], b: hcnt_q[7:5]};
            PAT_CHECK: pat = (hcnt_q[3] ^ vcnt_q[3]) ? '{r: 3'd7, g: 3'd7, b: 3'd7} : '0;
            PAT_ANIM:  pat = bar_colour(bar_k);
            default:   pat = '0;
        endcase

        if (blank) begin
            colour_d = '0;
        end else if (active) begin
            colour_d = pat;
        end else begin
            colour_d = '{r: {3{border[1]}}, g: {3{border[2]}}, b: {3{border[0]}}};
        end

        hsync_n_d    = ~hs_act;
        vsync_n_d    = ~vs_act;
        csync_n_d    = ~(hs_act ^ vs_act);
        frame_tick_d = wrap_q;
        frame_cnt_d  = frm_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clkvideo) begin
        if (!rst_n) begin
            hcnt_q       <= '0;
            vcnt_q       <= '0;
            mode_q       <= PAT_BARS;
            frm_q        <= '0;
            wrap_q       <= 1'b0;
            colour_q     <= '0;
            hsync_n_q    <= 1'b1;
            vsync_n_q    <= 1'b1;
            csync_n_q    <= 1'b1;
            frame_tick_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            hcnt_q       <= hcnt_d;
            vcnt_q       <= vcnt_d;
            mode_q       <= mode_d;
            frm_q        <= frm_d;
            wrap_q       <= wrap_d;
            colour_q     <= colour_d;
            hsync_n_q    <= hsync_n_d;
            vsync_n_q    <= vsync_n_d;
            csync_n_q    <= csync_n_d;
            frame_tick_q <= frame_tick_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign ro          = colour_q.r;
    assign go          = colour_q.g;
    assign bo          = colour_q.b;
    assign hsync_ext_n = hsync_n_q;
    assign vsync_ext_n = vsync_n_q;
    assign csync_ext_n = csync_n_q;
    assign frame_tick  = frame_tick_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_pal_test_timing_gen.sv
// Bench for pal_test_timing_gen: a default-timing instance and a shrunk-frame instance run
// side by side against a position/frame arithmetic reference model, with random mode/border.
module tb_pal_test_timing_gen;

    typedef struct {
        int ht, vt, ha, va, hb0, hb1, hs0, hs1, vs0, vs1;
    } timing_t;

    localparam timing_t P_FULL  = '{448, 312, 256, 192, 320, 416, 344, 376, 248, 252};
    localparam timing_t P_SMALL = '{160, 8, 128, 5, 136, 152, 140, 148, 6, 7};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode;
    logic [2:0] border;

    logic [2:0] ro_w [2];
    logic [2:0] go_w [2];
    logic [2:0] bo_w [2];
    logic       hs_w [2];
    logic       vs_w [2];
    logic       cs_w [2];
    logic       tick_w [2];
    logic [4:0] fc_w [2];

    int checks   = 0;
    int failures = 0;

    timing_t tp [2];
    longint  n_model [2];
    int      mode_model [2];

    always #5 clk = ~clk;

    pal_test_timing_gen dut_full (
        .clkvideo(clk), .rst_n(rst_n), .mode(mode), .border(border),
        .ro(ro_w[0]), .go(go_w[0]), .bo(bo_w[0]),
        .hsync_ext_n(hs_w[0]), .vsync_ext_n(vs_w[0]), .csync_ext_n(cs_w[0]),
        .frame_tick(tick_w[0]), .frame_cnt(fc_w[0])
    );

    pal_test_timing_gen #(
        .HTOTAL(160), .VTOTAL(8), .HACTIVE(128), .VACTIVE(5),
        .HBLANK_START(136), .HBLANK_END(152), .HSYNC_START(140), .HSYNC_END(148),
        .VSYNC_START(6), .VSYNC_END(7)
    ) dut_small (
        .clkvideo(clk), .rst_n(rst_n), .mode(mode), .border(border),
        .ro(ro_w[1]), .go(go_w[1]), .bo(bo_w[1]),
        .hsync_ext_n(hs_w[1]), .vsync_ext_n(vs_w[1]), .csync_ext_n(cs_w[1]),
        .frame_tick(tick_w[1]), .frame_cnt(fc_w[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lvl(input bit on);
        return on ? 7 : 0;
    endfunction

    // Expected outputs after the edge whose pre-edge state is cycle n since reset release.
    function automatic void model_out(input timing_t p, input longint n, input int me,
                                      input int bd, output int col, output int syn,
                                      output int tick, output int fc);
        longint frame = longint'(p.ht) * p.vt;
        longint f     = n / frame;
        int     pos   = int'(n % frame);
        int     h     = pos % p.ht;
        int     v     = pos / p.ht;
        bit     hs    = (h >= p.hs0) && (h < p.hs1);
        bit     vs    = (v >= p.vs0) && (v < p.vs1);
        int     frm   = int'(f % 32);
        int     k     = (h / 32) % 8;
        int     r, g, b;
        if ((h >= p.hb0 && h < p.hb1) || vs) begin
            r = 0; g = 0; b = 0;
        end else if (h < p.ha && v < p.va) begin
            if (me == 3) k = (k + frm / 4) % 8;
            if (me == 1) begin
                r = k; g = k; b = k;
            end else if (me == 2) begin
                r = lvl(((h / 8) % 2) != ((v / 8) % 2)); g = r; b = r;
            end else begin
                r = lvl((k / 2) % 2 == 1); g = lvl(k >= 4); b = lvl(k % 2 == 1);
            end
        end else begin
            r = lvl((bd / 2) % 2 == 1); g = lvl(bd >= 4); b = lvl(bd % 2 == 1);
        end
        col  = r * 64 + g * 8 + b;
        syn  = (hs ? 0 : 4) + (vs ? 0 : 2) + ((hs != vs) ? 0 : 1);
        tick = (pos == 0 && f > 0) ? 1 : 0;
        fc   = frm;
    endfunction

    task automatic step();
        int  col [2], syn [2], tick [2], fc [2];
        bit  in_reset = !rst_n;
        int  md       = int'(mode);
        for (int i = 0; i < 2; i++) begin
            if (in_reset) begin
                col[i] = 0; syn[i] = 7; tick[i] = 0; fc[i] = 0;
            end else begin
                model_out(tp[i], n_model[i], mode_model[i], int'(border),
                          col[i], syn[i], tick[i], fc[i]);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("inst%0d colour n=%0d", i, n_model[i]),
                  32'({ro_w[i], go_w[i], bo_w[i]}), 32'(col[i]));
            check($sformatf("inst%0d syncs n=%0d", i, n_model[i]),
                  32'({hs_w[i], vs_w[i], cs_w[i]}), 32'(syn[i]));
            check($sformatf("inst%0d frame_tick n=%0d", i, n_model[i]),
                  32'(tick_w[i]), 32'(tick[i]));
            check($sformatf("inst%0d frame_cnt n=%0d", i, n_model[i]),
                  32'(fc_w[i]), 32'(fc[i]));
            if (in_reset) begin
                n_model[i]    = 0;
                mode_model[i] = 0;
            end else begin
                if (n_model[i] % (longint'(tp[i].ht) * tp[i].vt) ==
                    longint'(tp[i].ht) * tp[i].vt - 1)
                    mode_model[i] = md;
                n_model[i]++;
            end
        end
    endtask

    initial begin
        tp[0] = P_FULL;
        tp[1] = P_SMALL;
        for (int i = 0; i < 2; i++) begin
            n_model[i]    = 0;
            mode_model[i] = 0;
        end
        rst_n  = 1'b0;
        mode   = 2'd0;
        border = 3'd0;
        #2;

        repeat (3) step();
        rst_n = 1'b1;

        // First line with mode 0 / border 0; reset for one clock at hcnt=350 (inside hsync).
        while (n_model[0] < 350) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

        // Long run: 33+ small frames (frame_cnt wraps), random border and mode changes.
        for (int c = 0; c < 33 * 1280 + 300; c++) begin
            step();
            if ($urandom_range(0, 63) == 0) border = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1499) == 0) mode = 2'($urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
